// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master.
//   state_e  : transaction sequencer states
//   PH0..PH3 : the four phases of one bit slot
//   ADDR_W   : slave address width (7 only)
//   DATA_W   : data byte width (8 only)
package i2c_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    STOP,
    DONE
  } state_e;

endpackage

// File: rtl/i2c_bit_timer.sv
// Phase and bit counters for the I2C master.
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : phase-advance enable from the clock divider
//   clear      : zero both counters (state boundary / idle); wins over tick
//   stall      : hold the phase even if tick=1 (clock stretching)
//   phase      : current phase within the bit slot (PH0..PH3)
//   bit_idx    : slot index within the current state
//   slot_end   : the current tick completes PH3 of the slot
module i2c_bit_timer
  import i2c_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       clear,
  input  logic       stall,
  output logic [1:0] phase,
  output logic [3:0] bit_idx,
  output logic       slot_end
);

  logic [1:0] phase_q;
  logic [3:0] bit_q;
  logic       advance;

  assign advance  = tick & ~stall;
  assign slot_end = advance & (phase_q == PH3);
  assign phase    = phase_q;
  assign bit_idx  = bit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH0;
      bit_q   <= 4'd0;
    end else if (clear) begin
      phase_q <= PH0;
      bit_q   <= 4'd0;
    end else if (advance) begin
      // Phase wraps PH3 -> PH0 on its own; the bit index steps at each slot end.
      phase_q <= phase_q + 2'd1;
      if (phase_q == PH3) begin
        bit_q <= bit_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_master_byte.sv
// Single-byte I2C master: START, 7-bit address + R/W, ACK, one data byte,
// ACK/NACK, STOP on open-drain SCL/SDA, paced by a one-clk tick enable.
//   clk, rst_n      : clock, asynchronous active-low reset
//   tick            : phase-advance enable from the clock divider
//   start           : request; accepted only in IDLE
//   addr, rw, wdata : latched on accept
//   rdata           : read byte, valid with done when rw=1
//   busy, done      : busy from accept until done; done is a one-clk pulse
//   ack_err         : a slave NACK was seen; held until the next accept
//   scl_oe, sda_oe  : 1 pulls the line low, 0 releases it
//   sda_in, scl_in  : sampled pads; scl_in only matters with stretching
// Optional feature macro: I2C_CLK_STRETCH_EN (slave clock stretching in P2/P3).
module i2c_master_byte
  import i2c_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              ack_err,
  output logic              scl_oe,
  output logic              sda_oe,
  input  logic              sda_in,
  input  logic              scl_in
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ack_err_q, ack_err_d;

  logic        accept, clear, stall, slot_end, sample, scl_high, last_bit;
  logic [1:0]  phase;
  logic [3:0]  bit_idx;
  logic [2:0]  bit_sel;
  logic [ADDR_W:0] addr_byte;

`ifdef I2C_CLK_STRETCH_EN
  // A slave holding SCL low while we release it freezes the slot.
  assign stall = scl_high & ~scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign stall         = 1'b0;
`endif

  i2c_bit_timer u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .clear    (clear),
    .stall    (stall),
    .phase    (phase),
    .bit_idx  (bit_idx),
    .slot_end (slot_end)
  );

  assign scl_high  = (phase == PH2) || (phase == PH3);
  assign sample    = tick & ~stall & (phase == PH2);
  assign last_bit  = (bit_idx == 4'd7);
  assign bit_sel   = 3'd7 - bit_idx[2:0];
  assign addr_byte = {addr_q, rw_q};

  // Next-state, counter clear and data capture.
  always_comb begin
    state_d   = state_q;
    clear     = 1'b0;
    accept    = 1'b0;
    ack_err_d = ack_err_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      IDLE: begin
        clear = 1'b1;
        if (start) begin
          accept    = 1'b1;
          ack_err_d = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        if (slot_end) begin
          clear   = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (slot_end && last_bit) begin
          clear   = 1'b1;
          state_d = ADDR_ACK;
        end
      end
      ADDR_ACK: begin
        if (sample && sda_in) begin
          ack_err_d = 1'b1;
        end
        // The ACK was sampled at the end of P2, so ack_err_q is current here.
        if (slot_end) begin
          clear   = 1'b1;
          state_d = ack_err_q ? STOP : DATA;
        end
      end
      DATA: begin
        if (sample && rw_q) begin
          rdata_d = {rdata_q[DATA_W-2:0], sda_in};
        end
        if (slot_end && last_bit) begin
          clear   = 1'b1;
          state_d = DATA_ACK;
        end
      end
      DATA_ACK: begin
        if (sample && !rw_q && sda_in) begin
          ack_err_d = 1'b1;
        end
        if (slot_end) begin
          clear   = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (slot_end) begin
          clear   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        clear   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus drive is a pure function of state and phase, so reset releases it at once.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    unique case (state_q)
      START: sda_oe = scl_high;
      ADDR: begin
        scl_oe = ~scl_high;
        sda_oe = ~addr_byte[bit_sel];
      end
      ADDR_ACK, DATA_ACK: scl_oe = ~scl_high;
      DATA: begin
        scl_oe = ~scl_high;
        sda_oe = ~rw_q & ~wdata_q[bit_sel];
      end
      STOP: begin
        scl_oe = (phase == PH0);
        sda_oe = ~scl_high;
      end
      default: begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      ack_err_q <= ack_err_d;
      if (accept) begin
        addr_q  <= addr;
        rw_q    <= rw;
        wdata_q <= wdata;
      end
    end
  end

  assign rdata   = rdata_q;
  assign ack_err = ack_err_q;
  assign done    = (state_q == DONE);
  assign busy    = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_i2c_master_byte.sv
// Self-checking bench for i2c_master_byte. A behavioural slave watches the
// resolved open-drain bus, records SDA at every SCL rising edge, counts START
// and STOP conditions and answers ACK/read data; a reference model builds the
// expected bit stream, tick count, ack_err and rdata from the protocol rules.
module tb_i2c_master_byte;

`ifdef I2C_CLK_STRETCH_EN
  localparam bit STRETCH_ON = 1'b1;
`else
  localparam bit STRETCH_ON = 1'b0;
`endif
  localparam int STRETCH_EXTRA = STRETCH_ON ? 10 : 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick;
  logic       start = 1'b0;
  logic [6:0] addr = '0;
  logic       rw = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       busy, done, ack_err, scl_oe, sda_oe;
  logic       sda_in, scl_in;
  logic       scl_bus, sda_bus;

  logic slave_pull = 1'b0;
  logic stretching = 1'b0;

  assign scl_bus = ~scl_oe & ~(stretching & STRETCH_ON);
  assign sda_bus = ~(sda_oe | slave_pull);
  assign scl_in  = scl_bus & ~stretching;
  assign sda_in  = sda_bus;

  i2c_master_byte dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .start   (start),
    .addr    (addr),
    .rw      (rw),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .scl_oe  (scl_oe),
    .sda_oe  (sda_oe),
    .sda_in  (sda_in),
    .scl_in  (scl_in)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slave configuration (written by tests only).
  logic       cfg_ack_a = 1'b1, cfg_ack_d = 1'b1, cfg_rw = 1'b0;
  logic [7:0] cfg_rd = '0;
  bit         tick_every = 1'b1;
  int         stretch_gen = 0;

  // Monitor / driver state (written by the always blocks only).
  logic prev_scl = 1'b1, prev_sda = 1'b1;
  logic seen[$];
  int   bit_pos = -100;
  int   start_cnt = 0, stop_cnt = 0, tick_cnt = 0;
  int   stretch_left = 0, stretch_gen_done = 0;

  function automatic logic slave_drive(input int pos);
    logic [7:0] t;
    if (pos == 8) return cfg_ack_a;
    if (pos >= 9 && pos <= 16) begin
      t = cfg_rd << (pos - 9);
      return cfg_rw && cfg_ack_a && !t[7];
    end
    if (pos == 17) return !cfg_rw && cfg_ack_a && cfg_ack_d;
    return 1'b0;
  endfunction

  // Bus monitor and slave responder.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_scl   = 1'b1;
      prev_sda   = 1'b1;
      slave_pull = 1'b0;
    end else begin
      if (prev_scl && scl_bus && prev_sda && !sda_bus) begin
        start_cnt++;
        bit_pos    = -1;
        slave_pull = 1'b0;
      end else if (prev_scl && scl_bus && !prev_sda && sda_bus) begin
        stop_cnt++;
      end
      if (!prev_scl && scl_bus) seen.push_back(sda_bus);
      if (prev_scl && !scl_bus) begin
        bit_pos++;
        slave_pull = slave_drive(bit_pos);
      end
      prev_scl = scl_bus;
      prev_sda = sda_bus;
    end
  end

  // Tick source, busy-tick counter and stretch controller.
  always @(negedge clk) begin
    if (stretch_gen != stretch_gen_done && busy && !scl_oe && bit_pos == 3 && !stretching) begin
      stretching       = 1'b1;
      stretch_left     = 10;
      stretch_gen_done = stretch_gen;
    end else if (stretching && stretch_left == 0) begin
      stretching = 1'b0;
    end
    tick = tick_every ? 1'b1 : ($urandom_range(0, 2) == 0);
    if (tick && busy) tick_cnt++;
    if (stretching && tick) stretch_left--;
  end

  // Reference model results.
  int          exp_len, exp_ticks;
  logic [31:0] exp_bits;
  logic        exp_err;
  logic [7:0]  model_rdata = '0;

  task automatic model(input logic [6:0] a, input logic r, input logic [7:0] wd,
                       input logic ack_a, input logic ack_d, input logic [7:0] rd);
    exp_bits = 32'({a, r, ~ack_a});
    exp_len  = 9;
    if (ack_a) begin
      exp_bits = {exp_bits[22:0], (r ? rd : wd), (r ? 1'b1 : ~ack_d)};
      exp_len  = 18;
    end
    // SCL rises once more inside STOP while SDA is still low.
    exp_bits  = {exp_bits[30:0], 1'b0};
    exp_len   = exp_len + 1;
    exp_ticks = ack_a ? 80 : 44;
    exp_err   = !ack_a || (!r && !ack_d);
    if (r && ack_a) model_rdata = rd;
  endtask

  // Observations from the last transaction.
  logic        obs_done, obs_busy_acc, obs_busy_done, obs_done_next, obs_err;
  logic [7:0]  obs_rdata;
  int          obs_ticks, obs_len, obs_starts, obs_stops;
  logic [31:0] obs_bits;

  task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                         input logic ack_a, input logic ack_d, input logic [7:0] rd,
                         input bit every, input bit stretch, input bit repulse);
    bit pulsed = 1'b0;
    int seen_base, start_base, stop_base, tick_base;
    cfg_ack_a  = ack_a;
    cfg_ack_d  = ack_d;
    cfg_rw     = r;
    cfg_rd     = rd;
    tick_every = every;
    if (stretch) stretch_gen++;
    @(negedge clk); #2;
    seen_base  = seen.size();
    start_base = start_cnt;
    stop_base  = stop_cnt;
    tick_base  = tick_cnt;
    addr = a; rw = r; wdata = wd; start = 1'b1;
    @(negedge clk); #2;
    obs_busy_acc = busy;
    // Scramble the inputs: the DUT must work from its latched copies.
    start = 1'b0; addr = 7'($urandom); rw = 1'($urandom); wdata = 8'($urandom);
    obs_done = 1'b0;
    for (int c = 0; c < 4000 && !obs_done; c++) begin
      if (done) begin
        obs_done = 1'b1;
      end else begin
        if (repulse && !pulsed && (tick_cnt - tick_base) >= 20) begin
          start = 1'b1; addr = 7'h11; rw = 1'b1; pulsed = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk); #2;
      end
    end
    start         = 1'b0;
    obs_ticks     = tick_cnt - tick_base;
    obs_busy_done = busy;
    obs_err       = ack_err;
    obs_rdata     = rdata;
    @(negedge clk); #2;
    obs_done_next = done;
    obs_starts    = start_cnt - start_base;
    obs_stops     = stop_cnt - stop_base;
    obs_len       = seen.size() - seen_base;
    obs_bits      = '0;
    for (int i = seen_base; i < seen.size(); i++) obs_bits = {obs_bits[30:0], seen[i]};
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #2;
    checks++; if (scl_oe !== 1'b0) begin errors++; $display("FAIL rst_scl_oe got %b want 0", scl_oe); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_sda_oe got %b want 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL rst_ack_err got %b want 0", ack_err); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got %h want 00", rdata); end
    rst_n = 1'b1;
  endtask

  task automatic test_write_ack;
    run_txn(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    model(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
    checks++; if (obs_done !== 1'b1) begin errors++; $display("FAIL wr_done got %b want 1", obs_done); end
    checks++; if (obs_busy_acc !== 1'b1) begin errors++; $display("FAIL wr_busy_accept got %b want 1", obs_busy_acc); end
    checks++; if (obs_ticks != exp_ticks) begin errors++; $display("FAIL wr_ticks got %0d want %0d", obs_ticks, exp_ticks); end
    checks++; if (obs_len != exp_len || obs_bits !== exp_bits) begin errors++; $display("FAIL wr_bits got %0d:%h want %0d:%h", obs_len, obs_bits, exp_len, exp_bits); end
    checks++; if (obs_starts != 1 || obs_stops != 1) begin errors++; $display("FAIL wr_start_stop got %0d/%0d want 1/1", obs_starts, obs_stops); end
    checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL wr_ack_err got %b want %b", obs_err, exp_err); end
    checks++; if (obs_busy_done !== 1'b0) begin errors++; $display("FAIL wr_busy_at_done got %b want 0", obs_busy_done); end
    checks++; if (obs_done_next !== 1'b0) begin errors++; $display("FAIL wr_done_pulse got %b want 0", obs_done_next); end
  endtask

  task automatic test_addr_nack;
    run_txn(7'h50, 1'b0, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    model(7'h50, 1'b0, 8'hA5, 1'b0, 1'b1, 8'h00);
    checks++; if (obs_ticks != exp_ticks) begin errors++; $display("FAIL nack_ticks got %0d want %0d", obs_ticks, exp_ticks); end
    checks++; if (obs_len != exp_len || obs_bits !== exp_bits) begin errors++; $display("FAIL nack_bits got %0d:%h want %0d:%h", obs_len, obs_bits, exp_len, exp_bits); end
    checks++; if (obs_stops != 1) begin errors++; $display("FAIL nack_stop got %0d want 1", obs_stops); end
    checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL nack_ack_err got %b want %b", obs_err, exp_err); end
  endtask

  task automatic test_read;
    run_txn(7'h50, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    model(7'h50, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C);
    checks++; if (obs_rdata !== model_rdata) begin errors++; $display("FAIL rd_rdata got %h want %h", obs_rdata, model_rdata); end
    checks++; if (obs_ticks != exp_ticks) begin errors++; $display("FAIL rd_ticks got %0d want %0d", obs_ticks, exp_ticks); end
    checks++; if (obs_len != exp_len || obs_bits !== exp_bits) begin errors++; $display("FAIL rd_bits got %0d:%h want %0d:%h", obs_len, obs_bits, exp_len, exp_bits); end
    checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL rd_ack_err got %b want %b", obs_err, exp_err); end
  endtask

  task automatic test_ignore_start;
    run_txn(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    model(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
    checks++; if (obs_len != exp_len || obs_bits !== exp_bits) begin errors++; $display("FAIL ign_bits got %0d:%h want %0d:%h", obs_len, obs_bits, exp_len, exp_bits); end
    checks++; if (obs_ticks != exp_ticks) begin errors++; $display("FAIL ign_ticks got %0d want %0d", obs_ticks, exp_ticks); end
    checks++; if (obs_starts != 1) begin errors++; $display("FAIL ign_starts got %0d want 1", obs_starts); end
  endtask

  task automatic test_reset_mid;
    int tick_base;
    bit reached = 1'b0;
    cfg_ack_a = 1'b1; cfg_ack_d = 1'b1; cfg_rw = 1'b0; tick_every = 1'b1;
    @(negedge clk); #2;
    tick_base = tick_cnt;
    addr = 7'h50; rw = 1'b0; wdata = 8'hA5; start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
    // Reach tick 15, then the next point where SCL is actively pulled low.
    for (int c = 0; c < 400 && !reached; c++) begin
      if ((tick_cnt - tick_base) >= 15 && scl_oe) reached = 1'b1;
      else begin @(negedge clk); #2; end
    end
    checks++; if (!reached || busy !== 1'b1) begin errors++; $display("FAIL rmid_pre got %b/%b want 1/1", reached, busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (scl_oe !== 1'b0) begin errors++; $display("FAIL rmid_scl_oe got %b want 0", scl_oe); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rmid_sda_oe got %b want 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rmid_rdata got %h want 00", rdata); end
    model_rdata = 8'h00;
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk); #2;
  endtask

  task automatic test_stretch;
    run_txn(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    model(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
    checks++; if (obs_ticks != exp_ticks + STRETCH_EXTRA) begin errors++; $display("FAIL str_ticks got %0d want %0d", obs_ticks, exp_ticks + STRETCH_EXTRA); end
    checks++; if (obs_len != exp_len || obs_bits !== exp_bits) begin errors++; $display("FAIL str_bits got %0d:%h want %0d:%h", obs_len, obs_bits, exp_len, exp_bits); end
    checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL str_ack_err got %b want %b", obs_err, exp_err); end
  endtask

  task automatic test_random;
    logic [6:0] a;
    logic [7:0] wd, rd;
    logic       r, ka, kd;
    bit         every;
    for (int n = 0; n < 8; n++) begin
      a = 7'($urandom); wd = 8'($urandom); rd = 8'($urandom); r = 1'($urandom);
      ka = ($urandom_range(0, 3) != 0); kd = ($urandom_range(0, 3) != 0);
      every = 1'($urandom);
      run_txn(a, r, wd, ka, kd, rd, every, 1'b0, 1'b0);
      model(a, r, wd, ka, kd, rd);
      checks++; if (obs_done !== 1'b1) begin errors++; $display("FAIL rnd%0d_done got %b want 1", n, obs_done); end
      checks++; if (obs_ticks != exp_ticks) begin errors++; $display("FAIL rnd%0d_ticks got %0d want %0d", n, obs_ticks, exp_ticks); end
      checks++; if (obs_len != exp_len || obs_bits !== exp_bits) begin errors++; $display("FAIL rnd%0d_bits got %0d:%h want %0d:%h", n, obs_len, obs_bits, exp_len, exp_bits); end
      checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL rnd%0d_ack_err got %b want %b", n, obs_err, exp_err); end
      checks++; if (obs_rdata !== model_rdata) begin errors++; $display("FAIL rnd%0d_rdata got %h want %h", n, obs_rdata, model_rdata); end
      checks++; if (obs_starts != 1 || obs_stops != 1) begin errors++; $display("FAIL rnd%0d_start_stop got %0d/%0d want 1/1", n, obs_starts, obs_stops); end
    end
  endtask

  initial begin
    test_reset;
    test_write_ack;
    test_addr_nack;
    test_read;
    test_ignore_start;
    test_reset_mid;
    test_stretch;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master_byte.md
Name: i2c_master_byte

Overview:
Single-byte I2C master transaction engine, directly downstream of the I2C clock divider. It consumes the divider's output as a one-clk-wide tick enable and generates START, 7-bit address plus R/W, ACK, one data byte, ACK/NACK and STOP on open-drain SCL/SDA. The host side uses a start/busy/done handshake. The bus pads (tri-state buffers) are outside this block.

Parameters:
ADDR_W, 7, slave address width; only 7 is supported.
DATA_W, 8, data byte width; only 8 is supported.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
tick  in  1  phase-advance enable, one clk wide, from the clock divider
start  in  1  transaction request; sampled only while busy=0
addr  in  7  slave address; latched on start accept
rw  in  1  0=write, 1=read; latched on start accept
wdata  in  8  write byte; latched on start accept
rdata  out  8  read byte; valid when done=1 and rw=1
busy  out  1  high from start accept until done
done  out  1  one-clk pulse at transaction end
ack_err  out  1  slave NACK seen; valid with done, held until next accept
scl_oe  out  1  1 = pull SCL low, 0 = release
sda_oe  out  1  1 = pull SDA low, 0 = release
sda_in  in  1  sampled SDA pad
scl_in  in  1  sampled SCL pad; used only with the optional feature

Behaviour:
- Reset values: scl_oe=0, sda_oe=0, busy=0, done=0, ack_err=0, rdata=0, state=IDLE. The bus is released.
- Reset asserted mid-transaction releases both lines asynchronously. No STOP is generated.
- Accept: in IDLE, start=1 latches addr, rw and wdata, sets busy=1, clears ack_err and enters START. It does not wait for tick.
- start while busy=1 is ignored.
- Every bit slot is 4 phases. The phase advances only on tick=1.
- Data-bit phases:
  - P0: SCL low; SDA updated to the new bit.
  - P1: SCL low.
  - P2: SCL released; SDA sampled on the tick that ends P2.
  - P3: SCL released.
- States and slots:
  - START: 1 slot. P0–P1 SCL and SDA released; P2–P3 SDA low with SCL released.
  - ADDR: 8 slots, MSB first: addr[6:0], then rw.
  - ADDR_ACK: 1 slot; master releases SDA and samples it.
  - DATA: 8 slots, MSB first.
    - Write: master drives wdata; a 1 bit means release.
    - Read: master releases SDA and shifts sampled bits into rdata.
  - DATA_ACK: 1 slot.
    - Write: master releases SDA and samples the ACK.
    - Read: master releases SDA (NACK, last byte).
  - STOP: 1 slot. P0 SCL low, SDA low; P1 SCL released, SDA low; P2–P3 both released.
  - DONE: done=1 and busy=0 in the same clk, then IDLE.
- Sampled ACK=1 sets ack_err=1.
  - Address NACK: DATA and DATA_ACK are skipped; go directly to STOP.
  - Data NACK on write: STOP follows normally.
- Length in ticks:
  - Full transaction: 80 ticks (1+9+9+1 slots × 4).
  - Address NACK: 44 ticks.
  - done rises the clk after the final STOP tick.
- A 4-bit bit counter and a 2-bit phase counter both wrap to 0 at slot and state boundaries.
- rdata is updated only during read DATA slots and is otherwise held.

Optional Feature:
I2C_CLK_STRETCH_EN
- Defined: in P2 and P3 the phase does not advance while scl_in=0, even if tick=1 (slave clock stretching). Ticks received while stretched are discarded.
- Undefined: scl_in is ignored and phases advance on tick alone.

Decomposition:
- Package i2c_pkg:
  - state enum: IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, DONE.
  - phase constants PH0–PH3.
  - ADDR_W and DATA_W.
- One natural sub-module, i2c_bit_timer: the phase and bit counters. Inputs tick, clear and stall; outputs phase, bit_idx and slot_end.

Test Plan:
- Write 0x50, wdata=0xA5, slave ACKs both bytes, tick every clk → SDA at the P2 samples reads 1010000,0,ACK,10100101,ACK, then STOP. done after 80 ticks, ack_err=0.
- Write 0x50, slave releases SDA at ADDR_ACK → no data slots, STOP, done after 44 ticks, ack_err=1.
- Read 0x50, slave drives 0x3C → rdata=0x3C at done, master SDA released in DATA_ACK (NACK), done after 80 ticks.
- start re-pulsed at tick 20 with addr=0x11 → ignored; bus shows 0x50 only.
- rst_n low at tick 15 → scl_oe=0 and sda_oe=0 immediately; busy=0, state IDLE.
- I2C_CLK_STRETCH_EN defined, scl_in held low for 10 ticks in the P2 of address bit 3 → transaction completes after 90 ticks with correct data.
